// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between fetch and LSU; data wins, a burst counter guards fetch
module mem_arbiter #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int MAX_DATA_BURST = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    instr_req_i,
    input  logic [ADDR_WIDTH-1:0]   instr_addr_i,
    output logic                    instr_gnt_o,
    output logic                    instr_rvalid_o,
    output logic [DATA_WIDTH-1:0]   instr_rdata_o,
    input  logic                    data_req_i,
    input  logic [ADDR_WIDTH-1:0]   data_addr_i,
    input  logic                    data_we_i,
    input  logic [DATA_WIDTH/8-1:0] data_be_i,
    input  logic [DATA_WIDTH-1:0]   data_wdata_i,
    output logic                    data_gnt_o,
    output logic                    data_rvalid_o,
    output logic [DATA_WIDTH-1:0]   data_rdata_o,
    output logic                    mem_req_o,
    output logic [ADDR_WIDTH-1:0]   mem_addr_o,
    output logic                    mem_we_o,
    output logic [DATA_WIDTH/8-1:0] mem_be_o,
    output logic [DATA_WIDTH-1:0]   mem_wdata_o,
    input  logic                    mem_gnt_i,
    input  logic                    mem_rvalid_i,
    input  logic [DATA_WIDTH-1:0]   mem_rdata_i
);
    localparam logic [2:0] MAX_B = 3'(MAX_DATA_BURST);
    typedef enum logic [1:0] {IDLE, REQ, RSP} state_e;
    state_e     state_q, state_d;
    logic       owner_q, owner_d;
    logic [2:0] starve_q, starve_d;
    logic       arb, any_req, win_data, in_req, rsp;
    // arbitration in IDLE or on the response cycle; owner_q=1 means the LSU owns the bus
    always_comb begin
        arb      = state_q == IDLE || (state_q == RSP && mem_rvalid_i);
        any_req  = instr_req_i || data_req_i;
        win_data = data_req_i && !(instr_req_i && starve_q == MAX_B);
        state_d  = state_q;
        owner_d  = owner_q;
        starve_d = starve_q;
        if (arb) begin
            state_d = any_req ? REQ : IDLE;
            if (any_req) begin
                owner_d  = win_data;
                starve_d = !win_data ? 3'd0 :
                           (instr_req_i && starve_q != MAX_B) ? starve_q + 3'd1 : starve_q;
            end
        end else if (state_q == REQ && mem_gnt_i) begin
            state_d = RSP;
        end
    end
    // state, owner and starvation counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            owner_q  <= 1'b0;
            starve_q <= 3'd0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            starve_q <= starve_d;
        end
    end
    assign in_req         = state_q == REQ;
    assign rsp            = state_q == RSP && mem_rvalid_i;
    assign mem_req_o      = in_req;
    assign mem_addr_o     = !in_req ? '0 : owner_q ? data_addr_i : instr_addr_i;
    assign mem_we_o       = in_req && owner_q && data_we_i;
    assign mem_be_o       = !in_req ? '0 : owner_q ? data_be_i : '1;
    assign mem_wdata_o    = (in_req && owner_q) ? data_wdata_i : '0;
    assign instr_gnt_o    = in_req && !owner_q && mem_gnt_i;
    assign data_gnt_o     = in_req && owner_q && mem_gnt_i;
    assign instr_rvalid_o = rsp && !owner_q;
    assign data_rvalid_o  = rsp && owner_q;
    assign instr_rdata_o  = instr_rvalid_o ? mem_rdata_i : '0;
    assign data_rdata_o   = data_rvalid_o ? mem_rdata_i : '0;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scoreboard bench for mem_arbiter
module tb_mem_arbiter;
    typedef struct packed {logic d; logic [31:0] addr; logic we; logic [3:0] be; logic [31:0] wdata;} txn_t;
    typedef struct packed {logic d; logic [31:0] rdata;} rsp_t;

    logic clk = 1'b0, rst;
    logic instr_req_i, instr_gnt_o, instr_rvalid_o;
    logic [31:0] instr_addr_i, instr_rdata_o;
    logic data_req_i, data_we_i, data_gnt_o, data_rvalid_o;
    logic [31:0] data_addr_i, data_wdata_i, data_rdata_o;
    logic [3:0] data_be_i, mem_be_o;
    logic mem_req_o, mem_we_o, mem_gnt_i, mem_rvalid_i;
    logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;

    int errors = 0, checks = 0, cyc = 0;
    int stall_cycles = 0, rsp_delay = 1;
    int i_rise, d_rise, i_gnt_cyc, d_gnt_cyc, i_rsp_cyc, d_rsp_cyc;
    logic i_gnt_seen = 1'b0, d_gnt_seen = 1'b0;
    txn_t iq[$], dq[$], exp_g[$];
    rsp_t exp_r[$];

    mem_arbiter dut (
        .clk(clk), .rst(rst),
        .instr_req_i(instr_req_i), .instr_addr_i(instr_addr_i), .instr_gnt_o(instr_gnt_o),
        .instr_rvalid_o(instr_rvalid_o), .instr_rdata_o(instr_rdata_o),
        .data_req_i(data_req_i), .data_addr_i(data_addr_i), .data_we_i(data_we_i),
        .data_be_i(data_be_i), .data_wdata_i(data_wdata_i), .data_gnt_o(data_gnt_o),
        .data_rvalid_o(data_rvalid_o), .data_rdata_o(data_rdata_o),
        .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_we_o(mem_we_o),
        .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o), .mem_gnt_i(mem_gnt_i),
        .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i)
    );

    initial forever #5 clk = ~clk;
    initial forever begin @(posedge clk); cyc++; end

    function automatic logic [31:0] rd(input logic [31:0] a);
        return a == 32'h100 ? 32'hDEADBEEF : ~a;
    endfunction
    function automatic txn_t itx(input logic [31:0] a);
        return '{d: 1'b0, addr: a, we: 1'b0, be: 4'hF, wdata: 32'h0};
    endfunction
    function automatic txn_t dtx(input logic [31:0] a, input logic we, input logic [3:0] be, input logic [31:0] wd);
        return '{d: 1'b1, addr: a, we: we, be: be, wdata: wd};
    endfunction

    task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // fetch requester: holds request until granted, then moves to the next queued address
    initial begin
        instr_req_i = 1'b0; instr_addr_i = '0;
        forever begin
            @(negedge clk);
            if (!instr_req_i || i_gnt_seen) begin
                if (iq.size() > 0) begin
                    if (!instr_req_i) i_rise = cyc;
                    instr_addr_i = iq.pop_front().addr;
                    instr_req_i = 1'b1;
                end else begin
                    instr_req_i = 1'b0; instr_addr_i = '0;
                end
            end
        end
    end

    // LSU requester
    initial begin
        txn_t t;
        data_req_i = 1'b0; data_addr_i = '0; data_we_i = 1'b0; data_be_i = '0; data_wdata_i = '0;
        forever begin
            @(negedge clk);
            if (!data_req_i || d_gnt_seen) begin
                if (dq.size() > 0) begin
                    if (!data_req_i) d_rise = cyc;
                    t = dq.pop_front();
                    data_addr_i = t.addr; data_we_i = t.we; data_be_i = t.be; data_wdata_i = t.wdata;
                    data_req_i = 1'b1;
                end else begin
                    data_req_i = 1'b0; data_addr_i = '0; data_we_i = 1'b0; data_be_i = '0; data_wdata_i = '0;
                end
            end
        end
    end

    // memory model: grant after stall_cycles waiting cycles, respond rsp_delay cycles after grant
    initial begin
        int wait_n, rsp_cnt;
        logic [31:0] rsp_data;
        wait_n = 0; rsp_cnt = 0; rsp_data = '0;
        mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = 32'hBAD0BAD0;
        forever begin
            @(negedge clk); #1;
            mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = 32'hBAD0BAD0;
            if (rsp_cnt > 0) begin
                rsp_cnt--;
                if (rsp_cnt == 0) begin mem_rvalid_i = 1'b1; mem_rdata_i = rsp_data; end
            end
            if (mem_req_o) begin
                if (wait_n < stall_cycles) wait_n++;
                else begin
                    mem_gnt_i = 1'b1; wait_n = 0; rsp_cnt = rsp_delay; rsp_data = rd(mem_addr_o);
                end
            end
        end
    end

    // monitor: pops the expected grant/response whenever the DUT presents one
    initial begin
        txn_t e;
        rsp_t r;
        forever begin
            @(negedge clk); #2;
            i_gnt_seen = instr_gnt_o; d_gnt_seen = data_gnt_o;
            if (instr_gnt_o || data_gnt_o) begin
                if (exp_g.size() == 0) chk("unexpected_gnt", 160'({instr_gnt_o, data_gnt_o}), 160'(0));
                else begin
                    e = exp_g.pop_front();
                    chk("gnt", 160'({mem_req_o, instr_gnt_o, data_gnt_o, mem_addr_o, mem_we_o, mem_be_o, mem_wdata_o}),
                        160'({1'b1, !e.d, e}));
                    if (data_gnt_o) d_gnt_cyc = cyc; else i_gnt_cyc = cyc;
                end
            end
            if (instr_rvalid_o || data_rvalid_o) begin
                if (exp_r.size() == 0) chk("unexpected_rsp", 160'({instr_rvalid_o, data_rvalid_o}), 160'(0));
                else begin
                    r = exp_r.pop_front();
                    chk("rsp", 160'({data_rvalid_o, instr_rvalid_o, data_rdata_o, instr_rdata_o}),
                        160'({r.d, !r.d, r.d ? r.rdata : 32'h0, r.d ? 32'h0 : r.rdata}));
                    if (data_rvalid_o) d_rsp_cyc = cyc; else i_rsp_cyc = cyc;
                end
            end else begin
                chk("idle_rdata", 160'({instr_rdata_o, data_rdata_o}), 160'(0));
            end
        end
    end

    function automatic logic [159:0] all_out();
        return 160'({instr_gnt_o, instr_rvalid_o, instr_rdata_o, data_gnt_o, data_rvalid_o, data_rdata_o,
                     mem_req_o, mem_addr_o, mem_we_o, mem_be_o, mem_wdata_o});
    endfunction

    task automatic do_reset();
        @(negedge clk); rst = 1'b1;
        @(negedge clk); #3;
        chk("reset_outputs", all_out(), 160'(0));
        @(negedge clk); rst = 1'b0; #3;
    endtask

    task automatic drain();
        for (int n = 0; n < 200 && (exp_g.size() + exp_r.size() + iq.size() + dq.size() > 0 || instr_req_i || data_req_i); n++)
            @(negedge clk);
        #3;
        chk("drain", 160'(exp_g.size() + exp_r.size() + iq.size() + dq.size()), 160'(0));
    endtask

    initial begin
        logic order [8];
        int di, ii;
        order = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        rst = 1'b1;
        // single fetch
        do_reset();
        iq.push_back(itx(32'h100));
        exp_g.push_back(itx(32'h100));
        exp_r.push_back('{d: 1'b0, rdata: 32'hDEADBEEF});
        drain();
        chk("fetch_gnt_latency", 160'(i_gnt_cyc - i_rise), 160'(1));
        chk("fetch_rsp_latency", 160'(i_rsp_cyc - i_rise), 160'(2));
        // data priority, fetch back-to-back after the write
        do_reset();
        dq.push_back(dtx(32'h2000, 1'b1, 4'b0011, 32'h1234));
        iq.push_back(itx(32'h104));
        exp_g.push_back(dtx(32'h2000, 1'b1, 4'b0011, 32'h1234));
        exp_g.push_back(itx(32'h104));
        exp_r.push_back('{d: 1'b1, rdata: 32'hFFFFDFFF});
        exp_r.push_back('{d: 1'b0, rdata: 32'hFFFFFEFB});
        drain();
        chk("back_to_back", 160'(i_gnt_cyc - d_rsp_cyc), 160'(1));
        // starvation guard: D,D,D,I,D,D,D,I
        do_reset();
        for (int k = 0; k < 6; k++) dq.push_back(dtx(32'h4000 + 32'(4 * k), k[0], 4'hF, 32'(k)));
        iq.push_back(itx(32'h200));
        iq.push_back(itx(32'h204));
        di = 0; ii = 0;
        for (int k = 0; k < 8; k++) begin
            if (order[k]) begin
                exp_g.push_back(dtx(32'h4000 + 32'(4 * di), di[0], 4'hF, 32'(di)));
                exp_r.push_back('{d: 1'b1, rdata: ~(32'h4000 + 32'(4 * di))});
                di++;
            end else begin
                exp_g.push_back(itx(32'h200 + 32'(4 * ii)));
                exp_r.push_back('{d: 1'b0, rdata: ~(32'h200 + 32'(4 * ii))});
                ii++;
            end
        end
        drain();
        // grant stall on a data read with a fetch waiting
        do_reset();
        stall_cycles = 5;
        dq.push_back(dtx(32'h3000, 1'b0, 4'hF, 32'h0));
        iq.push_back(itx(32'h108));
        exp_g.push_back(dtx(32'h3000, 1'b0, 4'hF, 32'h0));
        exp_g.push_back(itx(32'h108));
        exp_r.push_back('{d: 1'b1, rdata: 32'hFFFFCFFF});
        exp_r.push_back('{d: 1'b0, rdata: 32'hFFFFFEF7});
        @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk); #3;
            chk("stall_hold", 160'({mem_req_o, mem_addr_o, data_gnt_o, instr_gnt_o}), 160'({1'b1, 32'h3000, 1'b0, 1'b0}));
        end
        stall_cycles = 0;
        drain();
        chk("stall_gnt_cycle", 160'(d_gnt_cyc - d_rise), 160'(6));
        // reset while the response is outstanding, then a stale rvalid
        do_reset();
        rsp_delay = 3;
        iq.push_back(itx(32'h10C));
        exp_g.push_back(itx(32'h10C));
        for (int n = 0; n < 20 && !i_gnt_seen; n++) begin @(negedge clk); #3; end
        chk("rst_fetch_granted", 160'(i_gnt_seen), 160'(1));
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0; #3;
        chk("mid_reset_outputs", all_out(), 160'(0));
        @(negedge clk); #3;
        chk("stale_rvalid", 160'({mem_rvalid_i, instr_rvalid_o, data_rvalid_o}), 160'(3'b100));
        rsp_delay = 1;
        iq.push_back(itx(32'h110));
        exp_g.push_back(itx(32'h110));
        exp_r.push_back('{d: 1'b0, rdata: 32'hFFFFFEEF});
        drain();
        chk("post_reset_fetch_latency", 160'(i_rsp_cyc - i_rise), 160'(2));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1);
    end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-to-one memory port arbiter that shares a single request/grant/response memory bus between the instruction fetch path and the load store unit. It sits between the core and the unified memory. It serialises fetch and data accesses, with at most one outstanding transaction. Data accesses have priority, and a bounded starvation guard protects instruction fetch.

## Interface
Parameters:
- DATA_WIDTH, 32, data bus width; must be a multiple of 8
- ADDR_WIDTH, 32, address width
- MAX_DATA_BURST, 3, consecutive data grants allowed while fetch waits (1..7)

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  synchronous reset, active-high
- instr_req_i  in  1  fetch request; held with instr_addr_i until instr_gnt_o
- instr_addr_i  in  ADDR_WIDTH  fetch address
- instr_gnt_o  out  1  fetch request accepted by memory
- instr_rvalid_o  out  1  fetch response valid
- instr_rdata_o  out  DATA_WIDTH  fetched word
- data_req_i  in  1  LSU request; held with all attributes until data_gnt_o
- data_addr_i  in  ADDR_WIDTH  data address
- data_we_i  in  1  1 write, 0 read
- data_be_i  in  DATA_WIDTH/8  byte enables
- data_wdata_i  in  DATA_WIDTH  store data
- data_gnt_o  out  1  data request accepted
- data_rvalid_o  out  1  data response valid (reads and writes)
- data_rdata_o  out  DATA_WIDTH  load data
- mem_req_o  out  1  request to memory
- mem_addr_o  out  ADDR_WIDTH  memory address
- mem_we_o  out  1  memory write enable
- mem_be_o  out  DATA_WIDTH/8  memory byte enables
- mem_wdata_o  out  DATA_WIDTH  memory write data
- mem_gnt_i  in  1  memory accepts request this cycle
- mem_rvalid_i  in  1  memory response valid
- mem_rdata_i  in  DATA_WIDTH  memory read data

## Operation
- FSM states: IDLE, REQ, RSP. Registers: state, owner (INSTR/DATA), starve_cnt.
- Arbitration happens in IDLE, and in RSP on the cycle mem_rvalid_i=1. Rules:
  - Only data_req_i pending -> DATA.
  - Only instr_req_i pending -> INSTR.
  - Both pending -> DATA, unless starve_cnt == MAX_DATA_BURST; then INSTR.
- The winner is latched into owner and the FSM enters REQ. With no request pending, the FSM enters or stays in IDLE.
- starve_cnt:
  - Increments on a DATA win while instr_req_i=1.
  - Clears on any INSTR win.
  - Otherwise holds.
  - Saturates at MAX_DATA_BURST.
- REQ:
  - mem_req_o=1.
  - mem_addr_o, mem_we_o, mem_be_o and mem_wdata_o pass through combinationally from the owner's inputs.
  - For an INSTR owner: mem_we_o=0, mem_be_o all ones, mem_wdata_o=0.
  - On mem_gnt_i=1, the owner's gnt_o is 1 in the same cycle and the FSM goes to RSP. Otherwise it stays in REQ.
- RSP:
  - mem_req_o=0.
  - On mem_rvalid_i=1, the owner's rvalid_o=1 and its rdata_o=mem_rdata_i in the same cycle. The FSM then re-arbitrates as above.
- Responses are routed only to the owner. The non-owner's rvalid_o is 0 and its rdata_o is 0.
- Outside a routed response, both rdata_o outputs are 0.
- mem_rvalid_i is ignored in IDLE and REQ (protocol error, no effect).
- mem_gnt_i is ignored outside REQ.
- Requesters dropping req before gnt violate the protocol. The arbiter keeps mem_req_o asserted for the latched owner until gnt.

## Timing
- Reset values: state=IDLE, owner=INSTR, starve_cnt=0. All outputs are 0.
- Reset asserted mid-transaction returns to IDLE on the next edge. The outstanding response is dropped, and any later mem_rvalid_i is ignored.
- Latency: req_i rises in cycle 0 -> mem_req_o in cycle 1 -> gnt_o in the first cycle with mem_gnt_i (earliest cycle 1).
- rvalid_o follows mem_rvalid_i with zero cycles of delay.
- Back-to-back: a response cycle with another pending request gives mem_req_o=1 on the next cycle, with no IDLE bubble.
- One transaction outstanding at a time. A second mem_req_o never precedes the first mem_rvalid_i.
- A request arriving in the same cycle as a response is visible to that cycle's arbitration.
- All outputs are combinational from registered state plus the listed pass-through inputs. There are no combinational paths from mem_gnt_i or mem_rvalid_i to mem_req_o.

## Test plan
- Single fetch:
  - Stimulus: instr_req_i=1, addr 0x100; memory grants in cycle 1 and returns 0xDEADBEEF in cycle 2.
  - Required: mem_req_o=1 and mem_addr_o=0x100 in cycle 1; instr_gnt_o=1 in cycle 1; instr_rvalid_o=1 with 0xDEADBEEF in cycle 2; data_* outputs 0 throughout.
- Data priority:
  - Stimulus: both requests in cycle 0; data is a write to 0x2000, be=4'b0011, wdata 0x1234.
  - Required: the first memory transaction is the write (we=1, be=0011); the fetch follows back-to-back, with mem_req_o=1 the cycle after data_rvalid_o.
- Starvation guard:
  - Stimulus: instr_req_i and data_req_i held at 1 continuously, MAX_DATA_BURST=3, 1-cycle grant and response.
  - Required: grant order D,D,D,I,D,D,D,I.
- Grant stall:
  - Stimulus: mem_gnt_i held 0 for 5 cycles during a data read.
  - Required: mem_req_o and the address stay stable; data_gnt_o=0 until mem_gnt_i=1; no instruction grant in between.
- Reset mid-transaction:
  - Stimulus: rst asserted while in RSP, then a stale mem_rvalid_i after reset.
  - Required: all outputs 0 after the reset edge; the stale rvalid produces no rvalid_o; the next fetch proceeds normally.
